multicycle_ctrl: RTL

Multi-cycle control FSM for the RV64I core datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the immediate-format select consumed by the immediate generator, the register file, PC and memory handshake controls, and it keeps a retired-instruction counter. It sits between the instruction register and every datapath enable.

---
 rtl/multicycle_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_ctrl : fetch/decode/exec/mem/wb sequencer for the RV64I datapath
// Rev 1.0
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [2:0]  imm_sel,
  output logic        alu_src_imm,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        mem_err,
  output logic [63:0] instret,
  output logic [2:0]  state_o
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_NONE = 3'd7;

  // The timeout fires in the wait cycle that would bring the count to MEM_TIMEOUT.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [63:0] instret_q;
  logic [7:0]  wait_cnt;
  logic        retire;
  logic        timeout;
  logic        waiting;
  logic [6:0]  opcode;
  logic        is_load, is_opimm, is_jalr, is_store, is_op, is_branch, is_legal;
  logic [2:0]  imm_dec;
  logic        unused_instr_bits;

  assign opcode            = instr[6:0];
  assign unused_instr_bits = ^instr[31:7];

  assign is_load   = (opcode == OP_LOAD);
  assign is_opimm  = (opcode == OP_OPIMM);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_store  = (opcode == OP_STORE);
  assign is_op     = (opcode == OP_OP);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_legal  = is_load | is_opimm | is_jalr | is_store | is_op | is_branch;

  always_comb begin
    imm_dec = IMM_NONE;
    if (is_load || is_opimm || is_jalr) imm_dec = IMM_I;
    else if (is_store)                  imm_dec = IMM_S;
    else if (is_branch)                 imm_dec = IMM_B;
  end

  always_comb begin
    state_next  = state;
    retire      = 1'b0;
    timeout     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    imm_sel     = IMM_NONE;
    alu_src_imm = 1'b0;
    alu_op      = 2'd0;
    reg_write   = 1'b0;
    wb_sel      = 2'd0;
    illegal     = 1'b0;
    mem_err     = 1'b0;

    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          state_next = DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout    = 1'b1;
          state_next = FETCH;
        end
      end
      DECODE: begin
        imm_sel = imm_dec;
        if (is_legal) begin
          state_next = EXEC;
        end else begin
          illegal    = 1'b1;
          pc_write   = 1'b1;
          state_next = FETCH;
        end
      end
      EXEC: begin
        imm_sel     = imm_dec;
        alu_src_imm = is_load | is_opimm | is_jalr | is_store;
        if (is_branch)             alu_op = 2'd1;
        else if (is_op || is_opimm) alu_op = 2'd2;
        if (is_branch) begin
          pc_write   = 1'b1;
          pc_src     = branch_taken ? 2'd1 : 2'd0;
          retire     = 1'b1;
          state_next = FETCH;
        end else if (is_load || is_store) begin
          state_next = MEM;
        end else if (is_op || is_opimm || is_jalr) begin
          state_next = WB;
        end else begin
          state_next = FETCH;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_write   = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          timeout    = 1'b1;
          state_next = FETCH;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        retire     = 1'b1;
        pc_src     = is_jalr ? 2'd2 : 2'd0;
        if (is_load)      wb_sel = 2'd1;
        else if (is_jalr) wb_sel = 2'd2;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    mem_err = timeout;

    // Nothing may be enabled while reset is held.
    if (reset) begin
      state_next  = FETCH;
      retire      = 1'b0;
      timeout     = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'd0;
      imm_sel     = IMM_NONE;
      alu_src_imm = 1'b0;
      alu_op      = 2'd0;
      reg_write   = 1'b0;
      wb_sel      = 2'd0;
      illegal     = 1'b0;
      mem_err     = 1'b0;
    end
  end

  assign waiting = mem_req & ~mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      instret_q <= 64'd0;
      wait_cnt  <= 8'd0;
    end else begin
      state <= state_next;
      if (retire) instret_q <= instret_q + 64'd1;
      // Any state change (and a timeout re-fetch) starts a fresh wait window.
      if (state_next != state || timeout) wait_cnt <= 8'd0;
      else if (waiting)                   wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign instret = reset ? 64'd0 : instret_q;
  assign state_o = reset ? 3'd0 : state;

endmodule
`default_nettype wire
